// File: rtl/jtag_tap_master_if.sv
// Command/response bus between a host and jtag_tap_master.
// The host drives the master modport, the TAP master sits on the slave modport.
interface jtag_tap_master_if #(
   parameter int unsigned DR_MAX = 64,
   parameter int unsigned LW     = 7
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [LW-1:0]     cmd_len;
   logic [DR_MAX-1:0] cmd_data;
   logic              rsp_valid;
   logic [DR_MAX-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_len, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_len, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/jtag_tap_master.sv
// Bit-level JTAG master: walks a target TAP through reset, IR and DR scans with TCK = CK/2,
// shifting cmd_data out on TDI and collecting TDO into rsp_data.
module jtag_tap_master #(
   parameter int unsigned DR_MAX = 64,
   parameter int unsigned LW     = 7
) (
   input  logic             CK,
   input  logic             TRST,
   jtag_tap_master_if.slave bus,
   output logic             TCK_O,
   output logic             TMS_O,
   output logic             TDI_O,
   input  logic             TDO_I
);
   localparam int unsigned CW = $clog2(2 * DR_MAX + 16);
   localparam int unsigned IW = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;

   localparam logic [1:0] OpReset = 2'b00;
   localparam logic [1:0] OpIr    = 2'b01;

   typedef enum logic [1:0] {StStartup, StIdle, StRun, StDone} state_e;

   state_e            r_state, w_state_nxt;
   logic [CW-1:0]     r_cnt, w_cnt_nxt;
   logic [1:0]        r_op;
   logic [CW-1:0]     r_len;
   logic [DR_MAX-1:0] r_data;
   logic [DR_MAX-1:0] r_rsp;
   logic              r_err;

   logic              w_accept, w_bad, w_rst_seq, w_shift;
   logic [CW-1:0]     w_per, w_first, w_last, w_end;
   logic [IW-1:0]     w_idx;

   assign w_accept = (r_state == StIdle) && bus.cmd_valid;
   assign w_bad    = (bus.cmd_op == 2'b11) ||
                     ((bus.cmd_op != OpReset) &&
                      ((bus.cmd_len == '0) || (bus.cmd_len > LW'(DR_MAX))));

   // r_cnt is the CK cycle within the sequence (1-based): odd = TCK low, even = TCK high.
   always_comb begin
      w_rst_seq = (r_state == StStartup) || (r_op == OpReset);
      w_per     = (r_cnt - CW'(1)) >> 1;
      w_first   = (r_op == OpIr) ? CW'(4) : CW'(3);
      w_last    = w_first + r_len - CW'(1);
      w_idx     = IW'(w_per - w_first);
      w_shift   = (r_state == StRun) && !w_rst_seq && (w_per >= w_first) && (w_per <= w_last);
      w_end     = w_rst_seq ? CW'(12) : CW'((w_last + CW'(3)) << 1);
   end

   always_ff @(posedge CK or negedge TRST) begin
      if (!TRST) begin
         r_state <= StStartup;
         r_cnt   <= CW'(1);
         r_op    <= OpReset;
         r_len   <= '0;
         r_data  <= '0;
         r_rsp   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_op   <= bus.cmd_op;
            r_len  <= CW'(bus.cmd_len);
            r_data <= bus.cmd_data;
            r_rsp  <= '0;
            r_err  <= w_bad;
         end else if (w_shift && !r_cnt[0]) begin
            // TDO is taken on the edge where TCK falls
            r_rsp[w_idx] <= TDO_I;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CW'(1);
      unique case (r_state)
         StStartup: if (r_cnt == w_end) w_state_nxt = StIdle;
         StIdle: begin
            w_cnt_nxt = CW'(1);
            if (w_accept) w_state_nxt = w_bad ? StDone : StRun;
         end
         StRun:     if (r_cnt == w_end) w_state_nxt = StDone;
         StDone:    w_state_nxt = StIdle;
         default:   w_state_nxt = StStartup;
      endcase
   end

   always_comb begin
      bus.cmd_ready = (r_state == StIdle);
      bus.rsp_valid = (r_state == StDone);
      bus.rsp_data  = r_rsp;
      bus.rsp_err   = r_err;
      TCK_O         = 1'b0;
      TMS_O         = 1'b0;
      TDI_O         = 1'b0;
      if ((r_state == StStartup) || (r_state == StRun)) begin
         TCK_O = ~r_cnt[0];
         if (w_rst_seq) begin
            TMS_O = (w_per < CW'(5));
         end else begin
            // entry prefix (Select-DR[/IR]), leave Shift on the last bit, then Update, then Idle
            TMS_O = (w_per < w_first - CW'(2)) || (w_per == w_last) ||
                    (w_per == w_last + CW'(1));
         end
         TDI_O = w_shift & r_data[w_idx];
      end
   end
endmodule

// File: tb/tb_jtag_tap_master.sv
// Directed bench for jtag_tap_master against a behavioural TAP with a 2-bit IR and a bypass DR.
module tb_jtag_tap_master;
   localparam int unsigned DR_MAX = 64;
   localparam int unsigned LW     = 7;

   logic CK   = 1'b0;
   logic TRST = 1'b1;
   logic TCK_O, TMS_O, TDI_O;
   logic TDO_I = 1'b0;

   int n_vec = 0;
   int n_bad = 0;

   jtag_tap_master_if #(.DR_MAX(DR_MAX), .LW(LW)) bus ();

   jtag_tap_master #(.DR_MAX(DR_MAX), .LW(LW)) dut (
      .CK    (CK),
      .TRST  (TRST),
      .bus   (bus),
      .TCK_O (TCK_O),
      .TMS_O (TMS_O),
      .TDI_O (TDI_O),
      .TDO_I (TDO_I)
   );

   always #5 CK = ~CK;

   typedef enum logic [3:0] {
      Tlr, Rti, SelDr, CapDr, ShDr, Ex1Dr, PauDr, Ex2Dr, UpdDr,
      SelIr, CapIr, ShIr, Ex1Ir, PauIr, Ex2Ir, UpdIr
   } tap_e;

   tap_e         tap   = Tlr;
   logic         byp   = 1'b0;
   logic [1:0]   ir_sr = 2'b00;
   logic [1:0]   ir    = 2'b00;
   logic [255:0] tms_log = '0;
   int           tms_n = 0;

   // Target TAP: state and shift on TCK rise, TDO updated after TCK fall.
   always @(posedge TCK_O) begin
      if (tms_n < 256) tms_log[tms_n] = TMS_O;
      tms_n = tms_n + 1;
      case (tap)
         CapDr:   byp = 1'b0;
         ShDr:    byp = TDI_O;
         CapIr:   ir_sr = 2'b01;
         ShIr:    ir_sr = {TDI_O, ir_sr[1]};
         UpdIr:   ir = ir_sr;
         default: ;
      endcase
      case (tap)
         Tlr:     tap = TMS_O ? Tlr   : Rti;
         Rti:     tap = TMS_O ? SelDr : Rti;
         SelDr:   tap = TMS_O ? SelIr : CapDr;
         CapDr:   tap = TMS_O ? Ex1Dr : ShDr;
         ShDr:    tap = TMS_O ? Ex1Dr : ShDr;
         Ex1Dr:   tap = TMS_O ? UpdDr : PauDr;
         PauDr:   tap = TMS_O ? Ex2Dr : PauDr;
         Ex2Dr:   tap = TMS_O ? UpdDr : ShDr;
         UpdDr:   tap = TMS_O ? SelDr : Rti;
         SelIr:   tap = TMS_O ? Tlr   : CapIr;
         CapIr:   tap = TMS_O ? Ex1Ir : ShIr;
         ShIr:    tap = TMS_O ? Ex1Ir : ShIr;
         Ex1Ir:   tap = TMS_O ? UpdIr : PauIr;
         PauIr:   tap = TMS_O ? Ex2Ir : PauIr;
         Ex2Ir:   tap = TMS_O ? UpdIr : ShIr;
         default: tap = TMS_O ? SelDr : Rti;
      endcase
   end

   always @(negedge TCK_O) begin
      #1;
      TDO_I = (tap == ShDr) ? byp : ((tap == ShIr) ? ir_sr[0] : 1'b0);
   end

   // Issue one command; lat is the cycle (after acceptance) of rsp_valid, -1 if none came.
   task automatic run_cmd(input logic [1:0] op, input int len, input logic [DR_MAX-1:0] data,
                          output int lat, output logic [DR_MAX-1:0] rdat, output logic rerr,
                          output logic rdy1);
      lat  = -1;
      rdat = 'x;
      rerr = 1'bx;
      @(negedge CK);
      for (int w = 0; w < 300 && bus.cmd_ready !== 1'b1; w++) @(negedge CK);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_len   = LW'(len);
      bus.cmd_data  = data;
      tms_n         = 0;
      @(negedge CK);
      bus.cmd_valid = 1'b0;
      rdy1          = bus.cmd_ready;
      for (int c = 1; c <= 300; c++) begin
         if (c > 1) @(negedge CK);
         if (bus.rsp_valid === 1'b1) begin
            lat  = c;
            rdat = bus.rsp_data;
            rerr = bus.rsp_err;
            break;
         end
      end
   endtask

   // Assert TRST now, check async reset values, release, and follow the startup sequence.
   task automatic test_reset(input string nm);
      int first = 0;
      int rv    = 0;
      TRST = 1'b0;
      #1;
      n_vec++;
      if ({TCK_O, TMS_O, TDI_O, bus.cmd_ready, bus.rsp_valid, bus.rsp_err} !== 6'b010000) begin
         n_bad++;
         $display("FAIL %s reset pins: got %b want 010000", nm,
                  {TCK_O, TMS_O, TDI_O, bus.cmd_ready, bus.rsp_valid, bus.rsp_err});
      end
      n_vec++;
      if (bus.rsp_data !== '0) begin
         n_bad++;
         $display("FAIL %s reset rsp_data: got %h want 0", nm, bus.rsp_data);
      end
      tms_n = 0;
      repeat (2) @(negedge CK);
      TRST = 1'b1;
      for (int n = 2; n <= 40; n++) begin
         @(negedge CK);
         if (bus.cmd_ready === 1'b1 && first == 0) first = n;
         if (bus.rsp_valid !== 1'b0) rv++;
      end
      n_vec++;
      if (first != 13) begin
         n_bad++;
         $display("FAIL %s ready cycle: got %0d want 13", nm, first);
      end
      n_vec++;
      if (tms_n != 6 || tms_log[5:0] !== 6'b011111) begin
         n_bad++;
         $display("FAIL %s startup tms: got n=%0d %b want n=6 011111", nm, tms_n, tms_log[5:0]);
      end
      n_vec++;
      if (rv != 0) begin
         n_bad++;
         $display("FAIL %s spurious rsp_valid: got %0d want 0", nm, rv);
      end
      n_vec++;
      if (tap != Rti) begin
         n_bad++;
         $display("FAIL %s target state: got %0d want %0d", nm, tap, Rti);
      end
   endtask

   task automatic test_dr_bypass();
      int lat;
      logic [DR_MAX-1:0] rd;
      logic re, r1;
      run_cmd(2'b10, 8, 64'hA5, lat, rd, re, r1);
      n_vec++;
      if (lat != 27) begin n_bad++; $display("FAIL dr latency: got %0d want 27", lat); end
      n_vec++;
      if (rd !== 64'h4A || re !== 1'b0) begin
         n_bad++;
         $display("FAIL dr data: got %h err %b want 4a err 0", rd, re);
      end
      n_vec++;
      if (r1 !== 1'b0) begin n_bad++; $display("FAIL dr ready drop: got %b want 0", r1); end
      n_vec++;
      if (tms_n != 13 || tms_log[12:0] !== 13'h0C01) begin
         n_bad++;
         $display("FAIL dr tms: got n=%0d %h want n=13 0c01", tms_n, tms_log[12:0]);
      end
      @(negedge CK);
      n_vec++;
      if (bus.cmd_ready !== 1'b1 || tap != Rti) begin
         n_bad++;
         $display("FAIL dr ready return: got %b tap %0d want 1 tap %0d", bus.cmd_ready, tap, Rti);
      end
   endtask

   task automatic test_ir();
      int lat;
      logic [DR_MAX-1:0] rd;
      logic re, r1;
      run_cmd(2'b01, 2, 64'h2, lat, rd, re, r1);
      n_vec++;
      if (lat != 17) begin n_bad++; $display("FAIL ir latency: got %0d want 17", lat); end
      n_vec++;
      if (rd !== 64'h1 || re !== 1'b0) begin
         n_bad++;
         $display("FAIL ir data: got %h err %b want 1 err 0", rd, re);
      end
      n_vec++;
      if (ir !== 2'b10) begin n_bad++; $display("FAIL ir update: got %b want 10", ir); end
      n_vec++;
      if (tms_n != 8 || tms_log[7:0] !== 8'h63) begin
         n_bad++;
         $display("FAIL ir tms: got n=%0d %h want n=8 63", tms_n, tms_log[7:0]);
      end
   endtask

   task automatic test_errors();
      logic [1:0] ops  [3] = '{2'b11, 2'b10, 2'b10};
      int         lens [3] = '{8, 0, DR_MAX + 1};
      int lat;
      logic [DR_MAX-1:0] rd;
      logic re, r1;
      for (int i = 0; i < 3; i++) begin
         run_cmd(ops[i], lens[i], '1, lat, rd, re, r1);
         n_vec++;
         if (lat != 1 || re !== 1'b1 || rd !== '0) begin
            n_bad++;
            $display("FAIL err%0d rsp: got lat %0d err %b data %h want lat 1 err 1 data 0",
                     i, lat, re, rd);
         end
         n_vec++;
         if (tms_n != 0) begin n_bad++; $display("FAIL err%0d tck: got %0d rises want 0", i, tms_n); end
         @(negedge CK);
         n_vec++;
         if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL err%0d ready cycle 2: got %b want 1", i, bus.cmd_ready);
         end
      end
   endtask

   task automatic test_abort();
      int lat;
      logic [DR_MAX-1:0] rd;
      logic re, r1;
      @(negedge CK);
      for (int w = 0; w < 300 && bus.cmd_ready !== 1'b1; w++) @(negedge CK);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b10;
      bus.cmd_len   = LW'(16);
      bus.cmd_data  = 64'hBEEF;
      @(negedge CK);
      bus.cmd_valid = 1'b0;
      repeat (12) @(negedge CK);
      // cycle 13 is the low phase of the 4th shift bit: data bit 3 on TDI
      n_vec++;
      if (TDI_O !== 1'b1 || TMS_O !== 1'b0 || tap != ShDr) begin
         n_bad++;
         $display("FAIL abort mid-shift: got tdi %b tms %b tap %0d want 1 0 %0d",
                  TDI_O, TMS_O, tap, ShDr);
      end
      #2;
      test_reset("abort");
      run_cmd(2'b10, 16, 64'h1234, lat, rd, re, r1);
      n_vec++;
      if (lat != 43 || rd !== 64'h2468 || re !== 1'b0) begin
         n_bad++;
         $display("FAIL abort rescan: got lat %0d data %h err %b want 43 2468 0", lat, rd, re);
      end
   endtask

   task automatic test_back_to_back();
      int                lat  [3] = '{-1, -1, -1};
      logic [DR_MAX-1:0] rdat [3];
      logic              rerr [3];
      logic [255:0]      exp_tms = '0;
      int k = 0;
      int stage = 0;
      logic pending = 1'b1;
      for (int i = 0; i < 5; i++) exp_tms[i] = 1'b1;
      exp_tms[6]  = 1'b1;
      exp_tms[72] = 1'b1;
      exp_tms[73] = 1'b1;
      exp_tms[75] = 1'b1;
      exp_tms[76] = 1'b1;
      exp_tms[80] = 1'b1;
      exp_tms[81] = 1'b1;
      @(negedge CK);
      for (int w = 0; w < 300 && bus.cmd_ready !== 1'b1; w++) @(negedge CK);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_len   = '0;
      bus.cmd_data  = '0;
      tms_n         = 0;
      for (int c = 1; c <= 260 && k < 3; c++) begin
         @(negedge CK);
         if (pending) begin
            stage++;
            pending = 1'b0;
            if (stage == 1) begin
               bus.cmd_op   = 2'b10;
               bus.cmd_len  = LW'(DR_MAX);
               bus.cmd_data = '1;
            end else if (stage == 2) begin
               bus.cmd_op   = 2'b01;
               bus.cmd_len  = LW'(2);
               bus.cmd_data = 64'h3;
            end else begin
               bus.cmd_valid = 1'b0;
            end
         end
         if (bus.cmd_ready === 1'b1 && bus.cmd_valid === 1'b1) pending = 1'b1;
         if (bus.rsp_valid === 1'b1) begin
            lat[k]  = c;
            rdat[k] = bus.rsp_data;
            rerr[k] = bus.rsp_err;
            k++;
         end
      end
      bus.cmd_valid = 1'b0;
      n_vec++;
      if (lat[0] != 13 || lat[1] != 153 || lat[2] != 171) begin
         n_bad++;
         $display("FAIL b2b cycles: got %0d %0d %0d want 13 153 171", lat[0], lat[1], lat[2]);
      end
      n_vec++;
      if (rdat[1] !== 64'hFFFF_FFFF_FFFF_FFFE || rerr[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b dr data: got %h err %b want fffffffffffffffe err 0", rdat[1], rerr[1]);
      end
      n_vec++;
      if (rdat[2] !== 64'h1 || rerr[2] !== 1'b0 || rdat[0] !== '0 || rerr[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b rst/ir data: got %h/%b %h/%b want 0/0 1/0",
                  rdat[0], rerr[0], rdat[2], rerr[2]);
      end
      n_vec++;
      if (tms_n != 83 || tms_log[82:0] !== exp_tms[82:0]) begin
         n_bad++;
         $display("FAIL b2b tms: got n=%0d %h want n=83 %h", tms_n, tms_log[82:0], exp_tms[82:0]);
      end
      n_vec++;
      if (ir !== 2'b11) begin n_bad++; $display("FAIL b2b ir update: got %b want 11", ir); end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_len   = '0;
      bus.cmd_data  = '0;
      #13;
      test_reset("reset");
      test_dr_bypass();
      test_ir();
      test_errors();
      test_abort();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/jtag_tap_master.md
# jtag_tap_master

Bit-level JTAG master that drives a target TAP: it generates TCK, TMS and TDI and samples TDO. It sits on the tester/host side of the board-level scan chain, facing the TAP controller, instruction register and boundary-scan register of a JTAG-wrapped core. A host issues reset, IR-scan and DR-scan commands; the block walks the target TAP state machine, shifts the data and returns the captured TDO bits.

## Interface

Parameters:
- DR_MAX, 64: maximum scan length in bits, for both IR and DR.
- LW, 7: width of `cmd_len`; must satisfy 2^LW > DR_MAX.

Ports:
- `CK` in 1: system clock; all logic is on its rising edge.
- `TRST` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: the master can accept a command.
- `cmd_op` in 2: 00 = TAP reset to Run-Test/Idle, 01 = IR scan, 10 = DR scan, 11 = reserved, treated as an error.
- `cmd_len` in LW: number of bits to shift.
- `cmd_data` in DR_MAX: TDI bits; bit 0 is shifted first.
- `rsp_valid` out 1: one-CK-cycle pulse when the command completes.
- `rsp_data` out DR_MAX: captured TDO bits; bit 0 is captured first; bits at or above `cmd_len` read 0.
- `rsp_err` out 1: command was rejected; qualified by `rsp_valid`.
- `TCK_O` out 1: TAP clock, CK/2.
- `TMS_O` out 1: TAP mode select.
- `TDI_O` out 1: TAP data in.
- `TDO_I` in 1: TAP data out from the target.

## Operation

- **States:** STARTUP, IDLE, RUN, DONE.
- **TRST low:** all outputs are forced to reset values: `TCK_O`=0, `TMS_O`=1, `TDI_O`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0. State goes to STARTUP.
- **STARTUP:** sends the reset sequence (5× TMS=1, then 1× TMS=0), then goes to IDLE. No response is produced.
- **IDLE:** `cmd_ready`=1. A command is accepted when `cmd_valid && cmd_ready`. Op, len and data are latched at acceptance. `cmd_ready` drops in the following cycle.
- **Rejected commands:** `cmd_op`=11, or a scan with `cmd_len`=0 or `cmd_len` > DR_MAX. Go to DONE immediately with `rsp_err`=1 and `rsp_data`=0; there is no TCK activity.
- **TMS sequences.** The target starts each command in Run-Test/Idle. Per TCK period:
  - Reset: 1,1,1,1,1,0.
  - IR scan: 1,1,0,0, then N shift periods (TMS=0 except the last, which is 1), then 1,0.
  - DR scan: 1,0,0, then N shift periods (TMS=0 except the last, which is 1), then 1,0.
- **TDI_O:** carries `cmd_data[k]` during shift period k; it is 0 in every other period.
- **TDO capture:** `TDO_I` is captured into `rsp_data[k]` only during shift period k.
- **DONE:** `rsp_valid` is high for one cycle, then the state returns to IDLE. `rsp_data` and `rsp_err` hold until the next command is accepted.
- **TRST mid-command:** the command is abandoned and no response is produced. The block re-runs STARTUP.

## Timing

- **TCK period:** two CK cycles.
  - Low phase: `TCK_O`=0. `TMS_O`/`TDI_O` change only on the CK edge that begins this phase.
  - High phase: `TCK_O`=1.
- **TDO sample point:** `TDO_I` is sampled on the CK edge that ends the high phase, i.e. the edge where TCK falls.
- **Scan lengths in TCK periods (T):** reset T=6, IR scan T=N+6, DR scan T=N+5.
- **Accepted command:**
  - TCK period k (0-based) occupies CK cycles 2k+1 (low) and 2k+2 (high), counted from the acceptance edge.
  - `rsp_valid` is high in cycle 2T+1.
  - `cmd_ready` returns high in cycle 2T+2.
- **Rejected command:** `rsp_valid` is high in cycle 1 and `cmd_ready` is high in cycle 2.
- **STARTUP:** `cmd_ready` first rises in cycle 13 after TRST deasserts.
- **Back-to-back:** with `cmd_valid` held high, the next command is accepted on the first `cmd_ready` cycle. TCK has no extra idle periods except the single-cycle gaps for DONE and acceptance.
- **Throughput:** an N-bit DR scan costs 2N+12 CK cycles from acceptance to next acceptance.

## Test plan

- **Reset/startup:** pulse TRST low mid-cycle, then release. All outputs go to their reset values asynchronously. TMS over 6 TCK periods = 1,1,1,1,1,0. `cmd_ready` rises in cycle 13.
- **DR scan through bypass model:** a 1-bit delay target loaded with 0 at Capture-DR; `cmd_op`=10, len=8, data=0xA5. `rsp_data`=0x4A and `rsp_err`=0. `rsp_valid` appears in cycle 27. TMS = 1,0,0,0×7,1,1,0.
- **IR scan:** TAP model with a 2-bit IR that captures 2'b01; op=01, len=2, data=2'b10. `rsp_data`=2'b01 and the model's IR updates to 2'b10. TMS = 1,1,0,0,0,1,1,0.
- **Errors:** op=11; op=10 with len=0; len=DR_MAX+1. Each gives `rsp_valid` in cycle 1 with `rsp_err`=1, `rsp_data`=0, and `TCK_O` stays 0.
- **Abort:** assert TRST during the 4th shift bit of a 16-bit DR scan. No `rsp_valid` is produced, the STARTUP sequence repeats, and the next scan returns correct data.
- **Back-to-back:** `cmd_valid` held high for a reset, then a DR scan (len=DR_MAX, all ones), then an IR scan. Each response arrives at its computed cycle, and TMS never has an extra idle-high period.
